// File: rtl/floo_pkg.sv
// Collective-communication type encoding shared by the NoC links.
// Contents: collect_op_e, the 2-bit collect type carried with each flit.
package floo_pkg;

   typedef enum logic [1:0] {
      Unicast           = 2'd0,
      Multicast         = 2'd1,
      ParallelReduction = 2'd2,
      OffloadReduction  = 2'd3
   } collect_op_e;

endpackage

// File: rtl/picobello_pkg.sv
// Shared definitions for the collective performance monitor.
// Contents: counter kind encoding, counter-index helper, per-port event
// classifier and the monitor FSM state enum.
package picobello_pkg;

   localparam int unsigned KindMc    = 0;
   localparam int unsigned KindPr    = 1;
   localparam int unsigned KindOr    = 2;
   localparam int unsigned KindStall = 3;
   localparam int unsigned NumKinds  = 4;

   typedef enum logic [1:0] {
      Idle = 2'd0,
      Run  = 2'd1,
      Done = 2'd2
   } perf_state_e;

   function automatic int unsigned cnt_idx(input int unsigned chan, input int unsigned kind);
      return chan * NumKinds + kind;
   endfunction

   // Unicast traffic is never counted; a collective flit counts as a stall
   // while ready is low and as an event of its own kind on a handshake.
   function automatic logic event_hit(input logic        valid,
                                      input logic        ready,
                                      input logic [1:0]  commtype,
                                      input int unsigned kind);
      logic collect;
      logic hit;
      collect = valid && (commtype != floo_pkg::Unicast);
      hit     = 1'b0;
      if (kind == KindStall) begin
         hit = collect && !ready;
      end else if (kind == KindMc) begin
         hit = collect && ready && (commtype == floo_pkg::Multicast);
      end else if (kind == KindPr) begin
         hit = collect && ready && (commtype == floo_pkg::ParallelReduction);
      end else if (kind == KindOr) begin
         hit = collect && ready && (commtype == floo_pkg::OffloadReduction);
      end
      return hit;
   endfunction

endpackage

// File: rtl/picobello_sat_counter.sv
// Saturating event accumulator with synchronous clear.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   clr_i         clear count and overflow (wins over inc_i)
//   inc_i         per-cycle increment
//   cnt_nxt_o     value the counter takes at the next edge
//   ovf_nxt_o     sticky overflow the counter takes at the next edge
// The next-state values are exported so the owner can snapshot a count
// that already includes the current cycle's increment.
module picobello_sat_counter #(
   parameter int unsigned CntWidth = 32,
   parameter int unsigned IncWidth = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic [IncWidth-1:0] inc_i,
   output logic [CntWidth-1:0] cnt_nxt_o,
   output logic                ovf_nxt_o
);

   localparam int unsigned SumWidth = ((CntWidth > IncWidth) ? CntWidth : IncWidth) + 1;

   logic [CntWidth-1:0] cnt_q;
   logic                ovf_q;
   logic [SumWidth-1:0] sum;

   always_comb begin
      sum       = SumWidth'(cnt_q) + SumWidth'(inc_i);
      cnt_nxt_o = cnt_q;
      ovf_nxt_o = ovf_q;
      if (clr_i) begin
         cnt_nxt_o = '0;
         ovf_nxt_o = 1'b0;
      end else if (sum[SumWidth-1:CntWidth] != '0) begin
         cnt_nxt_o = '1;
         ovf_nxt_o = 1'b1;
      end else begin
         cnt_nxt_o = sum[CntWidth-1:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt_o;
         ovf_q <= ovf_nxt_o;
      end
   end

endmodule

// File: rtl/picobello_coll_perf_monitor.sv
// Windowed performance monitor for collective traffic on the router links.
// Counts multicast, parallel-reduction and offload-reduction handshakes and
// collective stalls per channel during a measurement window, then freezes
// them in a snapshot bank that software reads one counter at a time.
// Ports:
//   clk_i, rst_i             clock, async active-high reset
//   valid_i/ready_i          per channel/port link handshake
//   commtype_i               per channel/port collect type
//   start_i/stop_i           window start pulse / early window end
//   window_len_i             window length in cycles, 0 runs until stop_i
//   busy_o/done_o            window running / snapshot available
//   rd_req_i/rd_idx_i        snapshot read, index = channel*4 + kind
//   rd_valid_o/rd_data_o     read response, one cycle after the request
//   ovf_o                    saturation seen in the last snapshot
//
// state | meaning
// Idle  | after reset, no window measured yet
// Run   | window open, events accumulate
// Done  | snapshot taken, waiting for the next start
module picobello_coll_perf_monitor
   import picobello_pkg::*;
#(
   parameter int unsigned NumChannels = 3,
   parameter int unsigned NumPorts    = 5,
   parameter int unsigned CntWidth    = 32,
   parameter int unsigned WinWidth    = 24
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [NumChannels-1:0][NumPorts-1:0]      valid_i,
   input  logic [NumChannels-1:0][NumPorts-1:0]      ready_i,
   input  logic [NumChannels-1:0][NumPorts-1:0][1:0] commtype_i,
   input  logic                                      start_i,
   input  logic                                      stop_i,
   input  logic [WinWidth-1:0]                       window_len_i,
   output logic                                      busy_o,
   output logic                                      done_o,
   input  logic                                      rd_req_i,
   input  logic [$clog2(NumChannels*NumKinds)-1:0]   rd_idx_i,
   output logic                                      rd_valid_o,
   output logic [CntWidth-1:0]                       rd_data_o,
   output logic                                      ovf_o
);

   localparam int unsigned NumCnt   = NumChannels * NumKinds;
   localparam int unsigned IncWidth = $clog2(NumPorts + 1);

   perf_state_e         state_q, state_d;
   logic [WinWidth-1:0] win_q, win_d;
   logic                clr, cnt_en, snap_en;

   logic [CntWidth-1:0] cnt_nxt [NumCnt];
   logic [NumCnt-1:0]   ovf_nxt;
   logic [CntWidth-1:0] snap_q  [NumCnt];
   logic                snap_ovf_q;

   logic                rd_valid_q;
   logic [CntWidth-1:0] rd_data_q, rd_sel;

   // win_q is a down-counter of remaining Run cycles; 0 means open-ended.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      clr     = 1'b0;
      cnt_en  = 1'b0;
      snap_en = 1'b0;
      case (state_q)
         Idle, Done: begin
            if (start_i) begin
               clr     = 1'b1;
               win_d   = window_len_i;
               state_d = Run;
            end
         end
         Run: begin
            cnt_en = 1'b1;
            if (win_q != '0) begin
               win_d = win_q - WinWidth'(1);
            end
            if (stop_i || (win_q == WinWidth'(1))) begin
               snap_en = 1'b1;
               state_d = Done;
            end
         end
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= Idle;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
      end
   end

   for (genvar c = 0; c < NumChannels; c++) begin : g_chan
      for (genvar k = 0; k < NumKinds; k++) begin : g_kind
         localparam int unsigned Idx = cnt_idx(c, k);
         logic [IncWidth-1:0] inc;

         always_comb begin
            inc = '0;
            for (int p = 0; p < NumPorts; p++) begin
               if (event_hit(valid_i[c][p], ready_i[c][p], commtype_i[c][p], k)) begin
                  inc = inc + IncWidth'(1);
               end
            end
         end

         picobello_sat_counter #(
            .CntWidth (CntWidth),
            .IncWidth (IncWidth)
         ) i_cnt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .clr_i     (clr),
            .inc_i     (cnt_en ? inc : '0),
            .cnt_nxt_o (cnt_nxt[Idx]),
            .ovf_nxt_o (ovf_nxt[Idx])
         );
      end
   end

   // Snapshot takes the next-state counts so the final Run cycle is included.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumCnt; i++) begin
            snap_q[i] <= '0;
         end
         snap_ovf_q <= 1'b0;
      end else if (snap_en) begin
         for (int i = 0; i < NumCnt; i++) begin
            snap_q[i] <= cnt_nxt[i];
         end
         snap_ovf_q <= |ovf_nxt;
      end
   end

   always_comb begin
      rd_sel = '0;
      if (32'(rd_idx_i) < NumCnt) begin
         rd_sel = snap_q[rd_idx_i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_req_i;
         if (rd_req_i) begin
            rd_data_q <= rd_sel;
         end
      end
   end

   assign busy_o     = (state_q == Run);
   assign done_o     = (state_q == Done);
   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_data_q;
   assign ovf_o      = snap_ovf_q;

endmodule
